// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits MSB-first, parity bit, stop bit.
// Delivers the word in parallel with one-cycle status pulses and good/bad frame counters.
module serial_frame_rx #(
  parameter int WIDTH      = 8,
  parameter bit PARITY_ODD = 1'b0,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 din,
  output logic [WIDTH-1:0]     data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic                 busy
);
  localparam int BCW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 par_q, par_d;
  logic [WIDTH-1:0]     data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [CNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0] ecnt_q, ecnt_d;
  logic                 perr_c, ferr_c;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    data_out_d = data_out_q;
    fcnt_d     = fcnt_q;
    ecnt_d     = ecnt_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    perr_c     = (par_q != ((^shreg_q) ^ PARITY_ODD));
    ferr_c     = din;
    case (state_q)
      S_IDLE: begin
        if (din) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        shreg_d   = {shreg_q[WIDTH-2:0], din};
        bit_cnt_d = bit_cnt_q + BCW'(1);
        if (bit_cnt_q == BCW'(WIDTH-1)) state_d = S_PARITY;
      end
      S_PARITY: begin
        par_d   = din;
        state_d = S_STOP;
      end
      S_STOP: begin
        // A 1 here is the stop slot, never a start bit: always return to idle.
        state_d    = S_IDLE;
        data_out_d = shreg_q;
        perr_d     = perr_c;
        ferr_d     = ferr_c;
        if (!perr_c && !ferr_c) begin
          valid_d = 1'b1;
          fcnt_d  = fcnt_q + CNT_WIDTH'(1);
        end else if (ecnt_q != '1) begin
          ecnt_d = ecnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      fcnt_q     <= '0;
      ecnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      fcnt_q     <= fcnt_d;
      ecnt_q     <= ecnt_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign frame_cnt  = fcnt_q;
  assign err_cnt    = ecnt_q;
  assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed frames plus random streams, compared every cycle
// against a queue-based frame model, with literal expectations at key points.
module tb_serial_frame_rx;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         din;
  logic [W-1:0] data_out;
  logic         data_valid, parity_err, frame_err, busy;
  logic [7:0]   frame_cnt, err_cnt;

  serial_frame_rx #(.WIDTH(W), .PARITY_ODD(1'b0), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .din(din), .data_out(data_out),
    .data_valid(data_valid), .parity_err(parity_err), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: collect the bits of a frame once a 1 is seen while idle;
  // when WIDTH+3 bits are in hand, judge the frame as a whole.
  bit           q[$];
  logic [W-1:0] m_data;
  bit           m_valid, m_perr, m_ferr, m_busy;
  logic [7:0]   m_fcnt, m_ecnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_data = '0; m_valid = 0; m_perr = 0; m_ferr = 0; m_busy = 0;
      m_fcnt = '0; m_ecnt = '0;
    end else begin
      m_valid = 0; m_perr = 0; m_ferr = 0;
      if (q.size() == 0) begin
        if (din) q.push_back(1'b1);
      end else begin
        q.push_back(din);
        if (q.size() == W + 3) begin
          int ones;
          ones = 0;
          for (int i = 0; i < W; i++) begin
            m_data[W-1-i] = q[1+i];
            ones += int'(q[1+i]);
          end
          m_perr = (q[W+1] != bit'(ones % 2));
          m_ferr = q[W+2];
          if (!m_perr && !m_ferr) begin
            m_valid = 1;
            m_fcnt  = m_fcnt + 8'd1;
          end else if (m_ecnt != 8'hFF) begin
            m_ecnt = m_ecnt + 8'd1;
          end
          q.delete();
        end
      end
      m_busy = (q.size() != 0);
    end
  end

  // Per-cycle comparison, plus pulse bookkeeping from the DUT side.
  int cyc = 0;
  int vld_pulses = 0, perr_pulses = 0, ferr_pulses = 0;
  int last_vld = 0, prev_vld = 0;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      chk("data_out",   32'(data_out),   32'(m_data));
      chk("data_valid", 32'(data_valid), 32'(m_valid));
      chk("parity_err", 32'(parity_err), 32'(m_perr));
      chk("frame_err",  32'(frame_err),  32'(m_ferr));
      chk("frame_cnt",  32'(frame_cnt),  32'(m_fcnt));
      chk("err_cnt",    32'(err_cnt),    32'(m_ecnt));
      chk("busy",       32'(busy),       32'(m_busy));
      if (data_valid) begin
        vld_pulses++;
        prev_vld = last_vld;
        last_vld = cyc;
      end
      if (parity_err) perr_pulses++;
      if (frame_err)  ferr_pulses++;
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    din = b;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic par, input logic stp);
    send_bit(1'b1);
    for (int i = W - 1; i >= 0; i--) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " data_out"},   32'(data_out),   0);
    chk({nm, " data_valid"}, 32'(data_valid), 0);
    chk({nm, " parity_err"}, 32'(parity_err), 0);
    chk({nm, " frame_err"},  32'(frame_err),  0);
    chk({nm, " frame_cnt"},  32'(frame_cnt),  0);
    chk({nm, " err_cnt"},    32'(err_cnt),    0);
    chk({nm, " busy"},       32'(busy),       0);
  endtask

  initial begin
    logic [W-1:0] d;
    reset = 1'b1;
    din   = 1'b0;
    #8;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // Good 0xA5 frame
    send_frame(8'hA5, 1'b0, 1'b0);
    @(negedge clk); din = 1'b0;
    chk("a5 data_out", 32'(data_out), 32'hA5);
    chk("a5 data_valid", 32'(data_valid), 1);
    chk("a5 frame_cnt", 32'(frame_cnt), 1);
    chk("a5 err_cnt", 32'(err_cnt), 0);
    @(negedge clk);
    chk("a5 valid one cycle", 32'(data_valid), 0);
    idle(2);

    // Parity error
    send_frame(8'hA5, 1'b1, 1'b0);
    @(negedge clk); din = 1'b0;
    chk("perr flag", 32'(parity_err), 1);
    chk("perr valid", 32'(data_valid), 0);
    chk("perr data_out", 32'(data_out), 32'hA5);
    chk("perr err_cnt", 32'(err_cnt), 1);
    chk("perr frame_cnt", 32'(frame_cnt), 1);
    idle(2);

    // Stop bit 1, then a real start on the following edge
    send_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b0);
    @(negedge clk); din = 1'b0;
    chk("ferr err_cnt", 32'(err_cnt), 2);
    chk("ferr next frame_cnt", 32'(frame_cnt), 2);
    chk("ferr next data_out", 32'(data_out), 32'hA5);
    idle(3);
    chk("ferr pulses", 32'(ferr_pulses), 1);
    chk("perr pulses", 32'(perr_pulses), 1);

    // Back-to-back frames
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0);
    @(negedge clk); din = 1'b0;
    chk("b2b data_out", 32'(data_out), 32'hFF);
    chk("b2b frame_cnt", 32'(frame_cnt), 4);
    idle(2);
    chk("b2b valid pulses", 32'(vld_pulses), 4);
    chk("b2b spacing", 32'(last_vld - prev_vld), W + 3);

    // Asynchronous reset after 4 data bits
    send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_all_zero("midreset");
    @(negedge clk); @(negedge clk);
    reset = 1'b0; din = 1'b0;
    idle(1);
    send_frame(8'hA5, 1'b0, 1'b0);
    @(negedge clk); din = 1'b0;
    chk("post reset data_out", 32'(data_out), 32'hA5);
    chk("post reset frame_cnt", 32'(frame_cnt), 1);
    chk("post reset err_cnt", 32'(err_cnt), 0);

    // Counter wrap and saturation
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int n = 0; n < 256; n++) begin
      d = W'($urandom);
      send_frame(d, ^d, 1'b0);
      idle(int'($urandom_range(0, 1)));
    end
    idle(2);
    chk("wrap frame_cnt", 32'(frame_cnt), 0);
    chk("wrap err_cnt", 32'(err_cnt), 0);
    for (int n = 0; n < 260; n++) begin
      d = W'($urandom);
      send_frame(d, ~(^d), 1'b0);
      idle(int'($urandom_range(0, 1)));
    end
    idle(2);
    chk("sat err_cnt", 32'(err_cnt), 32'hFF);
    chk("sat frame_cnt", 32'(frame_cnt), 0);

    // Mixed random frames, then raw random bits
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int n = 0; n < 150; n++) begin
      d = W'($urandom);
      send_frame(d, ($urandom_range(0, 3) == 0) ? ~(^d) : ^d,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      idle(int'($urandom_range(0, 2)));
    end
    for (int n = 0; n < 400; n++) send_bit(1'($urandom));
    idle(W + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
